cvita_hdr_arbiter: RTL and testbench

Round-robin scheduler that shares one CVITA header output stream between NUM_PORTS requesters. It accepts header field sets from each port, assigns a per-port 12-bit sequence number, builds the CVITA header and serializes it as one or two 64-bit AXI-stream beats (header word, then optional VITA time). It sits in front of the payload mux in multi-stream transmit blocks; payload framing happens downstream, keyed by o_port.

---
 rtl/cvita_hdr_arbiter_pkg.sv | 60 ++++++
 rtl/cvita_rr_arb.sv | 32 +++
 rtl/cvita_hdr_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_cvita_hdr_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cvita_hdr_arbiter_pkg.sv
// Shared definitions for the CVITA header arbiter: packet-type encodings,
// header length constants, header bit-field positions and header helpers.
package cvita_hdr_arbiter_pkg;

  typedef enum logic [1:0] {
    PKT_TYPE_DATA = 2'b00,
    PKT_TYPE_FC   = 2'b01,
    PKT_TYPE_CMD  = 2'b10,
    PKT_TYPE_RESP = 2'b11
  } pkt_type_e;

  // Header bytes added to the payload length: one header word, plus the
  // VITA time word when present.
  localparam logic [15:0] HDR_LEN_NO_TIME = 16'd8;
  localparam logic [15:0] HDR_LEN_TIME    = 16'd16;

  localparam int SEQ_W = 12;

  // Header word field positions (LSB of each field).
  localparam int HDR_PKT_TYPE_LSB = 62;
  localparam int HDR_HAS_TIME_BIT = 61;
  localparam int HDR_EOB_BIT      = 60;
  localparam int HDR_SEQ_LSB      = 48;
  localparam int HDR_LEN_LSB      = 32;
  localparam int HDR_SRC_LSB      = 16;
  localparam int HDR_DST_LSB      = 0;

  // Total packet length in bytes; wraps modulo 2^16 on purpose.
  function automatic logic [15:0] hdr_length(input logic [15:0] payload_length,
                                             input logic        has_time);
    logic [15:0] len;
    if (has_time) begin
      len = payload_length + HDR_LEN_TIME;
    end else begin
      len = payload_length + HDR_LEN_NO_TIME;
    end
    return len;
  endfunction

  // Assemble the 64-bit CVITA header word from its fields.
  function automatic logic [63:0] build_hdr(input logic [1:0]       pkt_type,
                                            input logic             has_time,
                                            input logic             eob,
                                            input logic [SEQ_W-1:0] seqnum,
                                            input logic [15:0]      length,
                                            input logic [15:0]      src_sid,
                                            input logic [15:0]      dst_sid);
    logic [63:0] w;
    w = 64'd0;
    w[HDR_PKT_TYPE_LSB +: 2]     = pkt_type;
    w[HDR_HAS_TIME_BIT]          = has_time;
    w[HDR_EOB_BIT]               = eob;
    w[HDR_SEQ_LSB +: SEQ_W]      = seqnum;
    w[HDR_LEN_LSB +: 16]         = length;
    w[HDR_SRC_LSB +: 16]         = src_sid;
    w[HDR_DST_LSB +: 16]         = dst_sid;
    return w;
  endfunction

endpackage

// File: rtl/cvita_rr_arb.sv
// Combinational round-robin pick: first requesting port at or after
// (last_grant + 1) mod NUM_PORTS, reported as one-hot and as an index.
module cvita_rr_arb #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    last_grant,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PORT_W-1:0]    grant_idx,
  output logic                 grant_valid
);

  // Walk the ports in rotated priority order and keep the first hit.
  always_comb begin
    int  cand_s;
    logic hit_s;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand_s      = 0;
    hit_s       = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand_s      = (int'(last_grant) + i) % NUM_PORTS;
      hit_s       = !grant_valid && req[cand_s];
      grant[cand_s] = grant[cand_s] | hit_s;
      grant_idx   = hit_s ? PORT_W'(cand_s) : grant_idx;
      grant_valid = grant_valid | hit_s;
    end
  end

endmodule

// File: rtl/cvita_hdr_arbiter.sv
// Round-robin CVITA header arbiter. Grants one requester at a time, stamps a
// per-port 12-bit sequence number and emits the header word followed by the
// optional VITA time word on a 64-bit AXI-stream.
// Optional feature macro: CVITA_HDR_ARB_EOB_SEQ_RESET_EN -- when defined, the
// final beat of an eob=1 packet resets that port's sequence number to zero.
module cvita_hdr_arbiter
  import cvita_hdr_arbiter_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  localparam int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_PORTS-1:0]    i_req_valid,
  output logic [NUM_PORTS-1:0]    i_req_ready,
  input  logic [2*NUM_PORTS-1:0]  i_pkt_type,
  input  logic [NUM_PORTS-1:0]    i_eob,
  input  logic [NUM_PORTS-1:0]    i_has_time,
  input  logic [16*NUM_PORTS-1:0] i_payload_length,
  input  logic [16*NUM_PORTS-1:0] i_src_sid,
  input  logic [16*NUM_PORTS-1:0] i_dst_sid,
  input  logic [64*NUM_PORTS-1:0] i_vita_time,
  input  logic [NUM_PORTS-1:0]    i_seq_clear,
  output logic [63:0]             o_tdata,
  output logic                    o_tlast,
  output logic                    o_tvalid,
  input  logic                    o_tready,
  output logic [PORT_W-1:0]       o_port
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_TIME = 2'd2;

  logic [1:0]           state_r;
  logic [PORT_W-1:0]    last_grant_r;
  logic [PORT_W-1:0]    port_r;
  logic [63:0]          tdata_r;
  logic [63:0]          time_r;
  logic                 tvalid_r;
  logic                 tlast_r;
  logic [SEQ_W-1:0]     seqnum_r [NUM_PORTS];

  logic [NUM_PORTS-1:0] grant_s;
  logic [PORT_W-1:0]    grant_idx_s;
  logic                 grant_any_s;
  logic                 final_accept_s;

  logic [1:0]           sel_pkt_type_s;
  logic                 sel_eob_s;
  logic                 sel_has_time_s;
  logic [15:0]          sel_len_s;
  logic [15:0]          sel_src_s;
  logic [15:0]          sel_dst_s;
  logic [63:0]          sel_time_s;
  logic [SEQ_W-1:0]     sel_seq_s;

`ifdef CVITA_HDR_ARB_EOB_SEQ_RESET_EN
  logic                 eob_r;
`endif

  cvita_rr_arb #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_rr_arb (
    .req         (i_req_valid),
    .last_grant  (last_grant_r),
    .grant       (grant_s),
    .grant_idx   (grant_idx_s),
    .grant_valid (grant_any_s)
  );

  // Offer the arbitration result only while waiting for a new packet.
  always_comb begin
    if (state_r == ST_IDLE) begin
      i_req_ready = grant_s;
    end else begin
      i_req_ready = '0;
    end
  end

  // One-hot AND-OR mux of the granted port's fields and sequence number.
  always_comb begin
    sel_pkt_type_s = 2'b00;
    sel_eob_s      = 1'b0;
    sel_has_time_s = 1'b0;
    sel_len_s      = 16'd0;
    sel_src_s      = 16'd0;
    sel_dst_s      = 16'd0;
    sel_time_s     = 64'd0;
    sel_seq_s      = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      sel_pkt_type_s = sel_pkt_type_s | ({2{grant_s[p]}}      & i_pkt_type[2*p +: 2]);
      sel_eob_s      = sel_eob_s      | (grant_s[p]           & i_eob[p]);
      sel_has_time_s = sel_has_time_s | (grant_s[p]           & i_has_time[p]);
      sel_len_s      = sel_len_s      | ({16{grant_s[p]}}     & i_payload_length[16*p +: 16]);
      sel_src_s      = sel_src_s      | ({16{grant_s[p]}}     & i_src_sid[16*p +: 16]);
      sel_dst_s      = sel_dst_s      | ({16{grant_s[p]}}     & i_dst_sid[16*p +: 16]);
      sel_time_s     = sel_time_s     | ({64{grant_s[p]}}     & i_vita_time[64*p +: 64]);
      sel_seq_s      = sel_seq_s      | ({SEQ_W{grant_s[p]}}  & seqnum_r[p]);
    end
  end

  assign final_accept_s = tvalid_r && o_tready && tlast_r;

  // Packet FSM: latch the granted request, then present header and time beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      tvalid_r     <= 1'b0;
      tlast_r      <= 1'b0;
      tdata_r      <= 64'd0;
      time_r       <= 64'd0;
      port_r       <= '0;
      last_grant_r <= PORT_W'(NUM_PORTS - 1);
`ifdef CVITA_HDR_ARB_EOB_SEQ_RESET_EN
      eob_r        <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_any_s) begin
            tdata_r      <= build_hdr(sel_pkt_type_s, sel_has_time_s, sel_eob_s, sel_seq_s,
                                      hdr_length(sel_len_s, sel_has_time_s),
                                      sel_src_s, sel_dst_s);
            tlast_r      <= !sel_has_time_s;
            tvalid_r     <= 1'b1;
            time_r       <= sel_time_s;
            port_r       <= grant_idx_s;
            last_grant_r <= grant_idx_s;
            state_r      <= ST_HDR;
`ifdef CVITA_HDR_ARB_EOB_SEQ_RESET_EN
            eob_r        <= sel_eob_s;
`endif
          end
        end
        ST_HDR: begin
          if (o_tready) begin
            if (!tlast_r) begin
              tdata_r <= time_r;
              tlast_r <= 1'b1;
              state_r <= ST_TIME;
            end else begin
              tvalid_r <= 1'b0;
              tlast_r  <= 1'b0;
              state_r  <= ST_IDLE;
            end
          end
        end
        ST_TIME: begin
          if (o_tready) begin
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        default: begin
          tvalid_r <= 1'b0;
          tlast_r  <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  // Per-port sequence numbers: clear wins, otherwise advance on final beat.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (reset || i_seq_clear[p]) begin
        seqnum_r[p] <= '0;
      end else if (final_accept_s && (port_r == PORT_W'(p))) begin
`ifdef CVITA_HDR_ARB_EOB_SEQ_RESET_EN
        seqnum_r[p] <= eob_r ? '0 : seqnum_r[p] + 12'd1;
`else
        seqnum_r[p] <= seqnum_r[p] + 12'd1;
`endif
      end
    end
  end

  assign o_tdata  = tdata_r;
  assign o_tlast  = tlast_r;
  assign o_tvalid = tvalid_r;
  assign o_port   = port_r;

endmodule

// File: tb/tb_cvita_hdr_arbiter.sv
// Self-checking bench for cvita_hdr_arbiter: directed scenarios followed by
// randomized traffic, checked each cycle against a queue-based reference model.
module tb_cvita_hdr_arbiter;

  localparam int NP = 4;
  localparam int PW = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NP-1:0]     i_req_valid;
  logic [NP-1:0]     i_req_ready;
  logic [2*NP-1:0]   i_pkt_type;
  logic [NP-1:0]     i_eob;
  logic [NP-1:0]     i_has_time;
  logic [16*NP-1:0]  i_payload_length;
  logic [16*NP-1:0]  i_src_sid;
  logic [16*NP-1:0]  i_dst_sid;
  logic [64*NP-1:0]  i_vita_time;
  logic [NP-1:0]     i_seq_clear = '0;
  logic [63:0]       o_tdata;
  logic              o_tlast;
  logic              o_tvalid;
  logic              o_tready = 1'b0;
  logic [PW-1:0]     o_port;

  // Requester state, one entry per port.
  logic        rq_valid [NP];
  logic [1:0]  rq_pt    [NP];
  logic        rq_eob   [NP];
  logic        rq_ht    [NP];
  logic [15:0] rq_len   [NP];
  logic [15:0] rq_src   [NP];
  logic [15:0] rq_dst   [NP];
  logic [63:0] rq_time  [NP];

  for (genvar g = 0; g < NP; g++) begin : g_pack
    assign i_req_valid[g]               = rq_valid[g];
    assign i_pkt_type[2*g +: 2]         = rq_pt[g];
    assign i_eob[g]                     = rq_eob[g];
    assign i_has_time[g]                = rq_ht[g];
    assign i_payload_length[16*g +: 16] = rq_len[g];
    assign i_src_sid[16*g +: 16]        = rq_src[g];
    assign i_dst_sid[16*g +: 16]        = rq_dst[g];
    assign i_vita_time[64*g +: 64]      = rq_time[g];
  end

  cvita_hdr_arbiter #(.NUM_PORTS(NP)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_req_valid      (i_req_valid),
    .i_req_ready      (i_req_ready),
    .i_pkt_type       (i_pkt_type),
    .i_eob            (i_eob),
    .i_has_time       (i_has_time),
    .i_payload_length (i_payload_length),
    .i_src_sid        (i_src_sid),
    .i_dst_sid        (i_dst_sid),
    .i_vita_time      (i_vita_time),
    .i_seq_clear      (i_seq_clear),
    .o_tdata          (o_tdata),
    .o_tlast          (o_tlast),
    .o_tvalid         (o_tvalid),
    .o_tready         (o_tready),
    .o_port           (o_port)
  );

  always #5 clk = ~clk;

  // Reference model: queue of beats still to be emitted, per-port seqnums.
  typedef struct {
    logic [63:0] data;
    logic        last;
    int          port;
    logic        eob;
  } beat_t;

  beat_t mq [$];
  int    mseq [NP] = '{default: 0};
  int    mlast = NP - 1;
  int    grant_log [$];
  bit    granted [NP] = '{default: 1'b0};
  bit    after_reset = 1'b1;
  int    n_checks = 0;
  int    n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare DUT outputs with the model, then advance the model across the next edge.
  always @(negedge clk) begin
    int          pick;
    logic [NP-1:0] exp_ready;
    logic [15:0] len;
    beat_t       b;
    if (mq.size() == 0) begin
      chk("tvalid_idle", 64'(o_tvalid), 64'd0);
      chk("tlast_idle", 64'(o_tlast), 64'd0);
      if (after_reset) begin
        chk("tdata_rst", o_tdata, 64'd0);
        chk("port_rst", 64'(o_port), 64'd0);
      end
    end else begin
      chk("tvalid", 64'(o_tvalid), 64'd1);
      chk("tdata", o_tdata, mq[0].data);
      chk("tlast", 64'(o_tlast), 64'(mq[0].last));
      chk("port", 64'(o_port), 64'(mq[0].port));
    end
    #1;
    if (reset) begin
      mq.delete();
      for (int p = 0; p < NP; p++) mseq[p] = 0;
      mlast = NP - 1;
      after_reset = 1'b1;
    end else begin
      exp_ready = '0;
      if (mq.size() == 0) begin
        pick = -1;
        for (int i = 1; i <= NP; i++) begin
          if (pick < 0 && rq_valid[(mlast + i) % NP]) pick = (mlast + i) % NP;
        end
        if (pick >= 0) begin
          exp_ready[pick] = 1'b1;
          len = rq_len[pick] + (rq_ht[pick] ? 16'd16 : 16'd8);
          b.data = {rq_pt[pick], rq_ht[pick], rq_eob[pick], 12'(mseq[pick]), len,
                    rq_src[pick], rq_dst[pick]};
          b.last = !rq_ht[pick];
          b.port = pick;
          b.eob  = rq_eob[pick];
          mq.push_back(b);
          if (rq_ht[pick]) begin
            b.data = rq_time[pick];
            b.last = 1'b1;
            mq.push_back(b);
          end
          mlast = pick;
          grant_log.push_back(pick);
          granted[pick] = 1'b1;
          after_reset = 1'b0;
        end
      end else if (o_tready) begin
        b = mq.pop_front();
        if (b.last) begin
`ifdef CVITA_HDR_ARB_EOB_SEQ_RESET_EN
          mseq[b.port] = b.eob ? 0 : (mseq[b.port] + 1) % 4096;
`else
          mseq[b.port] = (mseq[b.port] + 1) % 4096;
`endif
        end
      end
      chk("req_ready", 64'(i_req_ready), 64'(exp_ready));
      for (int p = 0; p < NP; p++) if (i_seq_clear[p]) mseq[p] = 0;
    end
  end

  // Advance one cycle; drop requests the model saw accepted.
  task automatic step();
    @(posedge clk);
    #2;
    for (int p = 0; p < NP; p++) begin
      if (granted[p]) begin
        rq_valid[p] = 1'b0;
        granted[p]  = 1'b0;
      end
    end
  endtask

  task automatic req(input int p, input logic [1:0] pt, input logic ht, input logic eob,
                     input logic [15:0] len, input logic [63:0] t);
    rq_pt[p] = pt; rq_ht[p] = ht; rq_eob[p] = eob; rq_len[p] = len;
    rq_src[p] = 16'h0010; rq_dst[p] = 16'h0020; rq_time[p] = t;
    rq_valid[p] = 1'b1;
  endtask

  task automatic wait_grant(input int p);
    int n;
    n = 0;
    while (rq_valid[p] && n < 100) begin
      step();
      n++;
    end
    if (rq_valid[p]) begin
      n_checks++; n_fail++;
      $display("FAIL grant_timeout: port %0d never granted", p);
    end
  endtask

  task automatic wait_idle();
    int  n;
    bit  busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < 400) begin
      busy = (mq.size() != 0);
      for (int p = 0; p < NP; p++) busy = busy | rq_valid[p];
      if (busy) step();
      n++;
    end
    if (busy) begin
      n_checks++; n_fail++;
      $display("FAIL idle_timeout: arbiter did not drain");
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int p = 0; p < NP; p++) begin
      rq_valid[p] = 1'b0;
      granted[p]  = 1'b0;
    end
    step();
    step();
    reset = 1'b0;
    grant_log.delete();
  endtask

  initial begin
    int cnt [NP];
    for (int p = 0; p < NP; p++) begin
      rq_valid[p] = 1'b0; rq_pt[p] = 2'b00; rq_eob[p] = 1'b0; rq_ht[p] = 1'b0;
      rq_len[p] = 16'd0; rq_src[p] = 16'd0; rq_dst[p] = 16'd0; rq_time[p] = 64'd0;
    end
    repeat (3) step();
    reset = 1'b0;
    step();

    // Untimed packet on port 0, then a second one to see the seqnum advance.
    o_tready = 1'b1;
    req(0, 2'b00, 1'b0, 1'b0, 16'd100, 64'd0);
    wait_grant(0);
    chk("pin_hdr_p0_model", mq[0].data, 64'h0000_006C_0010_0020);
    chk("pin_hdr_p0_dut", o_tdata, 64'h0000_006C_0010_0020);
    chk("pin_tlast_p0", 64'(o_tlast), 64'd1);
    wait_idle();
    req(0, 2'b00, 1'b0, 1'b0, 16'd100, 64'd0);
    wait_grant(0);
    chk("pin_hdr_p0_seq1", o_tdata, 64'h0001_006C_0010_0020);
    wait_idle();

    // Timed packet on port 2.
    req(2, 2'b00, 1'b1, 1'b0, 16'd100, 64'h0123_4567_89AB_CDEF);
    wait_grant(2);
    chk("pin_hdr_p2", o_tdata, 64'h2000_0074_0010_0020);
    chk("pin_hdr_p2_tlast", 64'(o_tlast), 64'd0);
    chk("pin_hdr_p2_port", 64'(o_port), 64'd2);
    step();
    chk("pin_time_p2", o_tdata, 64'h0123_4567_89AB_CDEF);
    chk("pin_time_p2_tlast", 64'(o_tlast), 64'd1);
    chk("pin_time_p2_port", 64'(o_port), 64'd2);
    wait_idle();

    // All ports requesting continuously: rotation from port 0 after reset.
    do_reset();
    for (int p = 0; p < NP; p++) cnt[p] = 0;
    for (int k = 0; k < 60; k++) begin
      for (int p = 0; p < NP; p++) begin
        if (!rq_valid[p] && cnt[p] < 2) begin
          req(p, 2'b00, 1'b0, 1'b0, 16'(p * 4), 64'd0);
          cnt[p]++;
        end
      end
      step();
    end
    wait_idle();
    chk("rr_count", 64'(grant_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) chk("rr_order", 64'(grant_log[i]), 64'(i % 4));
    for (int p = 0; p < NP; p++) chk("rr_seq", 64'(mseq[p]), 64'd2);

    // Back-pressure: header held while o_tready is low, no new grants.
    o_tready = 1'b0;
    req(3, 2'b10, 1'b1, 1'b0, 16'd7, 64'hDEAD_BEEF_0000_0001);
    req(0, 2'b11, 1'b0, 1'b0, 16'd9, 64'd0);
    repeat (8) step();
    o_tready = 1'b1;
    wait_idle();

    // Seqnum wrap on port 1, length wrap, clear coincident with final beat.
    do_reset();
    for (int k = 0; k < 4096; k++) begin
      req(1, 2'b00, 1'b0, 1'b0, 16'd1, 64'd0);
      wait_grant(1);
    end
    wait_idle();
    chk("wrap_seq_model", 64'(mseq[1]), 64'd0);
    req(1, 2'b01, 1'b1, 1'b0, 16'hFFFC, 64'h55);
    wait_grant(1);
    chk("pin_len_wrap", o_tdata, 64'h6000_000C_0010_0020);
    step();
    i_seq_clear[1] = 1'b1;
    step();
    i_seq_clear[1] = 1'b0;
    wait_idle();
    chk("clear_seq_model", 64'(mseq[1]), 64'd0);
    req(1, 2'b00, 1'b0, 1'b0, 16'd0, 64'd0);
    wait_grant(1);
    chk("clear_seq_dut", 64'(o_tdata[59:48]), 64'd0);
    wait_idle();

    // Reset while the time beat is waiting.
    o_tready = 1'b0;
    req(2, 2'b00, 1'b1, 1'b0, 16'd32, 64'hAAAA_BBBB_CCCC_DDDD);
    wait_grant(2);
    o_tready = 1'b1;
    step();
    o_tready = 1'b0;
    chk("pre_rst_tlast", 64'(o_tlast), 64'd1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_tvalid", 64'(o_tvalid), 64'd0);
    o_tready = 1'b1;
    step();

    // eob effect on the following seqnum of port 0.
    req(0, 2'b00, 1'b0, 1'b1, 16'd4, 64'd0);
    wait_grant(0);
    wait_idle();
    req(0, 2'b00, 1'b0, 1'b0, 16'd4, 64'd0);
    wait_grant(0);
`ifdef CVITA_HDR_ARB_EOB_SEQ_RESET_EN
    chk("eob_seq", 64'(o_tdata[59:48]), 64'd0);
`else
    chk("eob_seq", 64'(o_tdata[59:48]), 64'd1);
`endif
    wait_idle();

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      o_tready = ($urandom_range(0, 9) < 7);
      for (int p = 0; p < NP; p++) begin
        if (!rq_valid[p] && ($urandom_range(0, 3) == 0)) begin
          req(p, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              16'($urandom), {$urandom, $urandom});
          rq_src[p] = 16'($urandom);
          rq_dst[p] = 16'($urandom);
        end
        i_seq_clear[p] = ($urandom_range(0, 49) == 0);
      end
      step();
    end
    i_seq_clear = '0;
    o_tready = 1'b1;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
